wrap_timer_scheduler: RTL

Multi-requester deadline scheduler built on a shared free-running wrapping cycle counter. It extends the external counter value by one wrap-tracking MSB, lets each of NUM_REQ requesters arm one relative-delay timer against that extended time base, and serialises expiries onto a single valid/ready fire channel with round-robin arbitration. It sits between the system cycle counter and the consumers that need timeouts or scheduled events, so they share one time base instead of each owning a counter.

---
 rtl/wrap_timer_pkg.sv | 35 +++
 rtl/wrap_time_extend.sv | 33 +++
 rtl/wrap_timer_scheduler.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/wrap_timer_pkg.sv
// Shared types and modular-time helpers for the wrapping timer scheduler.
// Covers both builds of wrap_timer_scheduler (TIMER_CANCEL_EN defined or not).
package wrap_timer_pkg;

  typedef enum logic [1:0] {
    SLOT_IDLE    = 2'd0,
    SLOT_ARMED   = 2'd1,
    SLOT_EXPIRED = 2'd2
  } slot_state_e;

  // Widest extended time base the helpers support (16-bit counter + wrap bit).
  localparam int MAX_TIME_W = 17;

  function automatic logic [MAX_TIME_W-1:0] mod_diff(
    input logic [MAX_TIME_W-1:0] now,
    input logic [MAX_TIME_W-1:0] deadline,
    input int unsigned           width
  );
    logic [MAX_TIME_W-1:0] mask;
    mask = {MAX_TIME_W{1'b1}} >> (MAX_TIME_W - width);
    return (now - deadline) & mask;
  endfunction

  // A deadline counts as reached once now is at or past it within half the range.
  function automatic logic time_reached(
    input logic [MAX_TIME_W-1:0] now,
    input logic [MAX_TIME_W-1:0] deadline,
    input int unsigned           width
  );
    logic [MAX_TIME_W-1:0] diff;
    diff = mod_diff(now, deadline, width);
    return !diff[width-1];
  endfunction

endpackage

// File: rtl/wrap_time_extend.sv
// Registers the external wrapping counter and adds one wrap-tracking MSB,
// giving a time base twice the counter's range.
module wrap_time_extend
  import wrap_timer_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic [W-1:0] cnt_value,
  output logic [W:0]   ext_time
);

  logic [W-1:0] cnt_q;
  logic         ext_msb;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q   <= '0;
      ext_msb <= 1'b0;
    end else begin
      cnt_q <= cnt_value;
      if (cnt_q[W-1] && !cnt_value[W-1]) begin
        ext_msb <= ~ext_msb;
      end
    end
  end

  assign ext_time = {ext_msb, cnt_q};

endmodule

// File: rtl/wrap_timer_scheduler.sv
// Per-slot relative-delay timers on a shared extended time base, expiries
// serialised round-robin onto one valid/ready channel. Optional TIMER_CANCEL_EN.
module wrap_timer_scheduler
  import wrap_timer_pkg::*;
#(
  parameter int CNT_WIDTH = 9,
  parameter int NUM_REQ   = 4,
  parameter int ID_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [CNT_WIDTH-1:0]         cnt_value,
  input  logic [NUM_REQ-1:0]           arm_valid,
  input  logic [NUM_REQ*CNT_WIDTH-1:0] arm_delay,
  output logic [NUM_REQ-1:0]           arm_ready,
`ifdef TIMER_CANCEL_EN
  input  logic [NUM_REQ-1:0]           cancel,
`endif
  output logic                         fire_valid,
  output logic [ID_WIDTH-1:0]          fire_id,
  input  logic                         fire_ready,
  output logic [NUM_REQ-1:0]           busy
);

  localparam int TW = CNT_WIDTH + 1;

  logic [TW-1:0]       ext_time;
  slot_state_e         state_q       [NUM_REQ];
  logic [TW-1:0]       deadline_q    [NUM_REQ];
  logic [TW-1:0]       deadline_next [NUM_REQ];
  logic [NUM_REQ-1:0]  reached;
  logic [NUM_REQ-1:0]  expired;
  logic [NUM_REQ-1:0]  presented;
  logic [NUM_REQ-1:0]  cancel_eff;
  logic [NUM_REQ-1:0]  arm_go;
  logic [NUM_REQ-1:0]  eligible;
  logic                fire_done;
  logic [ID_WIDTH-1:0] rr_ptr_q;
  logic                grant_found;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [ID_WIDTH-1:0] grant_next_ptr;
  int                  cand;

  wrap_time_extend #(.W(CNT_WIDTH)) u_time (
    .clk       (clk),
    .resetn    (resetn),
    .cnt_value (cnt_value),
    .ext_time  (ext_time)
  );

  assign fire_done = fire_valid && fire_ready;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    presented = '0;
    if (fire_valid) begin
      presented[fire_id] = 1'b1;
    end
`ifdef TIMER_CANCEL_EN
    cancel_eff = cancel & ~presented;
`else
    cancel_eff = '0;
`endif
    arm_go = arm_valid & ~cancel_eff;
    for (int i = 0; i < NUM_REQ; i++) begin
      deadline_next[i] = ext_time + ((arm_delay[i*CNT_WIDTH +: CNT_WIDTH] == '0)
                         ? TW'(1) : TW'(arm_delay[i*CNT_WIDTH +: CNT_WIDTH]));
      reached[i]   = time_reached(MAX_TIME_W'(ext_time), MAX_TIME_W'(deadline_q[i]), TW);
      expired[i]   = (state_q[i] == SLOT_EXPIRED);
      busy[i]      = (state_q[i] != SLOT_IDLE);
      arm_ready[i] = (state_q[i] == SLOT_IDLE);
    end
    // A slot being cancelled this cycle must not be handed to the channel.
    eligible = expired & ~presented & ~cancel_eff;
  end

  // Round-robin search starting at rr_ptr_q.
  always_comb begin
    grant_found    = 1'b0;
    grant_idx      = '0;
    grant_next_ptr = '0;
    cand           = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_WIDTH'(cand);
      end
    end
    if (int'(grant_idx) != NUM_REQ - 1) begin
      grant_next_ptr = grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        state_q[i] <= SLOT_IDLE;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        unique case (state_q[i])
          SLOT_IDLE: begin
            if (arm_go[i]) state_q[i] <= SLOT_ARMED;
          end
          SLOT_ARMED: begin
            if (cancel_eff[i])   state_q[i] <= SLOT_IDLE;
            else if (reached[i]) state_q[i] <= SLOT_EXPIRED;
          end
          SLOT_EXPIRED: begin
            if (cancel_eff[i] || (fire_done && fire_id == ID_WIDTH'(i))) begin
              state_q[i] <= SLOT_IDLE;
            end
          end
          default: state_q[i] <= SLOT_IDLE;
        endcase
      end
    end
  end

  // NOTE: deadlines carry no reset; a deadline is only read while its slot is
  // ARMED, and arming always writes it first.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++) begin
      if (state_q[i] == SLOT_IDLE && arm_go[i]) begin
        deadline_q[i] <= deadline_next[i];
      end
    end
  end

  // Output registers reload when empty or on a handshake, allowing one fire per cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fire_valid <= 1'b0;
      fire_id    <= '0;
      rr_ptr_q   <= '0;
    end else if (!fire_valid || fire_ready) begin
      fire_valid <= grant_found;
      if (grant_found) begin
        fire_id  <= grant_idx;
        rr_ptr_q <= grant_next_ptr;
      end
    end
  end

endmodule
